bus_cycle_ctrl: RTL
===================

BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 Parameter ADDR_BITS, 20, address bus width.
REQ-002 Parameter DATA_BITS, 8, data bus width.
REQ-003 Parameter MEM_SEL_BIT, 19, address bit selecting MEM1 (0) / MEM2 (1) on memory cycles.
REQ-004 Parameter IO_SEL_BIT, 15, address bit selecting IO1 (0) / IO2 (1) on IO cycles.
REQ-005 CLK  input  1  single clock, all state changes on rising edge.
REQ-006 RESET  input  1  asynchronous, active-low reset.
REQ-007 req  input  1  host transaction request, held until done.
REQ-008 req_wr  input  1  1 = write, 0 = read; sampled with req.
REQ-009 req_iom  input  1  1 = memory cycle, 0 = IO cycle; sampled with req.
REQ-010 req_addr  input  ADDR_BITS  transaction address.
REQ-011 req_wdata  input  DATA_BITS  write data.
REQ-012 done  output  1  one-cycle pulse, transaction complete.
REQ-013 rdata  output  DATA_BITS  read data, valid while done=1, held until next read.
REQ-014 READY  input  1  slave ready, used only with wait states compiled in.
REQ-015 ALE  output  1  address latch enable, high only in T1.
REQ-016 Address  output  ADDR_BITS  bus address, driven T1..T4.
REQ-017 IOM  output  1  cycle type to slaves.
REQ-018 RD  output  1  active-low read strobe.
REQ-019 WR  output  1  active-low write strobe.
REQ-020 CS  output  4  one-hot chip selects: [0] IO1, [1] IO2, [2] MEM1, [3] MEM2.
REQ-021 Data  inout  DATA_BITS  shared bidirectional data bus.

Function
REQ-022 States: TI (idle), T1, T2, T3, TW (wait), T4.
REQ-023 TI -> T1 when req=1; request fields latched into internal registers on that edge; req ignored in all other states.
REQ-024 T1: ALE=1, CS, IOM and Address driven from latched request; RD=WR=1; T1 -> T2 unconditionally.
REQ-025 T2: read drives RD=0; write drives WR=0 and Data=latched wdata; T2 -> T3.
REQ-026 T3: strobe and write data held; read captures Data into rdata on the T3 exit edge; T3 -> T4 (or TW, see REQ-035).
REQ-027 T4: RD=WR=1, Data released to high-Z, done=1 for exactly this cycle; CS and Address still held.
REQ-028 T4 -> T1 when req=1 (back-to-back, new fields latched, no TI cycle); otherwise T4 -> TI.
REQ-029 Latency: req seen in TI to done = 4 cycles without waits.
REQ-030 Data driven by this block only in T2/T3 of write cycles; high-Z at all other times.
REQ-031 CS exactly one-hot in T1..T4, all zero in TI; decode from latched iom and MEM_SEL_BIT/IO_SEL_BIT.
REQ-032 RD and WR never low simultaneously.

Reset
REQ-033 RESET=0 forces TI immediately regardless of state: ALE=0, RD=WR=IOM=1, CS=0, Address=0, Data high-Z, done=0, rdata=0.
REQ-034 Reset mid-transaction aborts without a done pulse; first cycle after release is TI.

Configuration
REQ-035 WAIT_STATE_EN defined: in T3 and TW, READY=0 -> TW, READY=1 -> T4; read data captured on the edge leaving to T4; strobes and Data held through TW.
REQ-036 WAIT_STATE_EN undefined: TW absent, READY ignored, T3 -> T4 always.

Structure
REQ-037 Package bus_pkg holds the state enum (TI,T1,T2,T3,TW,T4), CS index constants, default widths.
REQ-038 Sub-module bus_cs_decode: combinational iom/address to one-hot CS, instantiated once.

Verification
REQ-039 Memory read addr 0x80010, memory slave returns 0xA5 -> CS=4'b1000, ALE in T1 only, RD low T2-T3, done on cycle 4, rdata=0xA5.
REQ-040 IO write addr 0x00020 data 0x3C -> CS=4'b0001, IOM=0, WR low T2-T3, Data=0x3C in T2-T3, slave location 0x00020 reads back 0x3C.
REQ-041 req held high over two reads -> T4 followed directly by T1, done pulses 4 cycles apart.
REQ-042 RESET=0 asserted during T3 of a write -> outputs at reset values same cycle, no done, Data high-Z.
REQ-043 WAIT_STATE_EN, READY low 2 cycles in T3 -> two TW cycles, done on cycle 6, rdata captured at TW exit.

Source files
------------

// File: rtl/bus_pkg.sv
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared state encoding, chip-select indices and default widths
//                for the bus cycle controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_pkg;

   typedef enum logic [2:0] {
      TI = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      TW = 3'd4,
      T4 = 3'd5
   } bus_state_t;

   localparam int c_CS_IO1  = 0;
   localparam int c_CS_IO2  = 1;
   localparam int c_CS_MEM1 = 2;
   localparam int c_CS_MEM2 = 3;

   localparam int c_ADDR_BITS   = 20;
   localparam int c_DATA_BITS   = 8;
   localparam int c_MEM_SEL_BIT = 19;
   localparam int c_IO_SEL_BIT  = 15;

endpackage

`default_nettype wire

// File: rtl/bus_cs_decode.sv
// ============================================================================
//  Module      : bus_cs_decode
//  Description : Combinational one-hot chip-select decode from cycle type and
//                address.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_cs_decode
   import bus_pkg::*;
#(
   parameter int ADDR_BITS   = c_ADDR_BITS,
   parameter int MEM_SEL_BIT = c_MEM_SEL_BIT,
   parameter int IO_SEL_BIT  = c_IO_SEL_BIT
) (
   input  logic                 iom,
   input  logic [ADDR_BITS-1:0] addr,
   output logic [3:0]           cs
);

   // Only the two select bits matter; the rest of the address is folded here.
   logic w_unused_addr;
   assign w_unused_addr = ^addr;

   always_comb begin
      cs = 4'b0000;
      if (iom) begin
         if (addr[MEM_SEL_BIT]) cs[c_CS_MEM2] = 1'b1;
         else                   cs[c_CS_MEM1] = 1'b1;
      end else begin
         if (addr[IO_SEL_BIT])  cs[c_CS_IO2]  = 1'b1;
         else                   cs[c_CS_IO1]  = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_cycle_ctrl.sv
// ============================================================================
//  Module      : bus_cycle_ctrl
//  Description : Host-to-bus cycle sequencer (TI/T1/T2/T3/T4), optional wait
//                states enabled by the WAIT_STATE_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_cycle_ctrl
   import bus_pkg::*;
#(
   parameter int ADDR_BITS   = c_ADDR_BITS,
   parameter int DATA_BITS   = c_DATA_BITS,
   parameter int MEM_SEL_BIT = c_MEM_SEL_BIT,
   parameter int IO_SEL_BIT  = c_IO_SEL_BIT
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 req,
   input  logic                 req_wr,
   input  logic                 req_iom,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [DATA_BITS-1:0] req_wdata,
   output logic                 done,
   output logic [DATA_BITS-1:0] rdata,
   input  logic                 READY,
   output logic                 ALE,
   output logic [ADDR_BITS-1:0] Address,
   output logic                 IOM,
   output logic                 RD,
   output logic                 WR,
   output logic [3:0]           CS,
   inout  wire  [DATA_BITS-1:0] Data
);

   bus_state_t           r_state;
   bus_state_t           w_state_nxt;
   logic                 r_wr;
   logic                 r_iom;
   logic [ADDR_BITS-1:0] r_addr;
   logic [DATA_BITS-1:0] r_wdata;
   logic [DATA_BITS-1:0] r_rdata;
   logic [3:0]           w_cs_dec;
   logic                 w_active;
   logic                 w_strobe;
   logic                 w_accept;
   logic                 w_capture;

`ifndef WAIT_STATE_EN
   logic w_unused_ready;
   assign w_unused_ready = READY;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TI: if (req) w_state_nxt = T1;
         T1: w_state_nxt = T2;
         T2: w_state_nxt = T3;
`ifdef WAIT_STATE_EN
         T3: w_state_nxt = READY ? T4 : TW;
         TW: w_state_nxt = READY ? T4 : TW;
`else
         T3: w_state_nxt = T4;
         TW: w_state_nxt = T4;
`endif
         T4: w_state_nxt = req ? T1 : TI;
         default: w_state_nxt = TI;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) r_state <= TI;
      else        r_state <= w_state_nxt;
   end

   // Request fields are only sampled on the edge that enters T1.
   assign w_accept  = ((r_state == TI) || (r_state == T4)) && req;
   assign w_capture = ((r_state == T3) || (r_state == TW)) && (w_state_nxt == T4) && !r_wr;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_wr    <= 1'b0;
         r_iom   <= 1'b1;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_wr    <= req_wr;
         r_iom   <= req_iom;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)         r_rdata <= '0;
      else if (w_capture) r_rdata <= Data;
   end

   bus_cs_decode #(
      .ADDR_BITS   (ADDR_BITS),
      .MEM_SEL_BIT (MEM_SEL_BIT),
      .IO_SEL_BIT  (IO_SEL_BIT)
   ) u_cs_decode (
      .iom  (r_iom),
      .addr (r_addr),
      .cs   (w_cs_dec)
   );

   // Outputs decode straight from state so an async reset takes effect at once.
   assign w_active = (r_state != TI);
   assign w_strobe = (r_state == T2) || (r_state == T3) || (r_state == TW);

   assign ALE     = (r_state == T1);
   assign Address = w_active ? r_addr : '0;
   assign IOM     = w_active ? r_iom : 1'b1;
   assign CS      = w_active ? w_cs_dec : 4'b0000;
   assign RD      = !(w_strobe && !r_wr);
   assign WR      = !(w_strobe && r_wr);
   assign done    = (r_state == T4);
   assign rdata   = r_rdata;
   assign Data    = (w_strobe && r_wr) ? r_wdata : {DATA_BITS{1'bz}};

endmodule

`default_nettype wire
